// File: rtl/ttc_tx.sv
// TTC serializer: 16-bit frames MSB first, BIT_CYCLES clocks per bit, SYNC burst then data/idle frames.
// Accepted word reaches dataout the cycle after the next frame boundary; word_ready drops while the one-entry buffer is full or in SYNC.
module ttc_tx #(
  parameter int          BIT_CYCLES  = 4,
  parameter logic [15:0] SYNC_WORD   = 16'hF0F0,
  parameter logic [15:0] IDLE_WORD   = 16'hAAAA,
  parameter int          SYNC_FRAMES = 8
) (
  input  logic        clk640,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        resync,
  output logic        dataout,
  output logic        frame_start,
  output logic        is_data,
  output logic [15:0] tx_count
);

  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int SW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(BIT_CYCLES - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_FRAMES - 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] phase;
  logic [3:0]    bit_idx;
  logic [SW-1:0] sync_cnt;
  logic [15:0]   shreg;
  logic [15:0]   buf_word;
  logic          buf_full;
  logic          resync_pend;
  logic          primed;
  logic [15:0]   tx_cnt;

  logic last_phase;
  logic boundary;
  logic accept;

  // The first edge after reset behaves as a boundary so the first SYNC frame starts immediately.
  assign last_phase  = (phase == PH_LAST);
  assign boundary    = !primed || (last_phase && (bit_idx == 4'd0));
  assign word_ready  = (state == ST_RUN) && !buf_full;
  assign accept      = word_valid && word_ready;
  assign dataout     = shreg[15];
  assign tx_count    = tx_cnt;

  always_ff @(posedge clk640 or posedge rst) begin
    if (rst) begin
      state       <= ST_SYNC;
      phase       <= '0;
      bit_idx     <= 4'd0;
      sync_cnt    <= '0;
      shreg       <= 16'h0000;
      buf_word    <= 16'h0000;
      buf_full    <= 1'b0;
      resync_pend <= 1'b0;
      primed      <= 1'b0;
      tx_cnt      <= 16'h0000;
      frame_start <= 1'b0;
      is_data     <= 1'b0;
    end else begin
      frame_start <= boundary;

      if (accept) begin
        buf_word <= word_in;
        buf_full <= 1'b1;
      end

      if (resync) begin
        resync_pend <= 1'b1;
      end

      if (boundary) begin
        primed      <= 1'b1;
        phase       <= '0;
        bit_idx     <= 4'd15;
        // A pulse landing on the boundary itself is held for the following boundary.
        resync_pend <= resync;
        if (primed && is_data) begin
          tx_cnt <= tx_cnt + 16'd1;
        end

        if (!primed) begin
          shreg   <= SYNC_WORD;
          is_data <= 1'b0;
        end else if (resync_pend) begin
          state    <= ST_SYNC;
          sync_cnt <= '0;
          shreg    <= SYNC_WORD;
          is_data  <= 1'b0;
        end else if ((state == ST_SYNC) && (sync_cnt != SYNC_LAST)) begin
          sync_cnt <= sync_cnt + 1'b1;
          shreg    <= SYNC_WORD;
          is_data  <= 1'b0;
        end else begin
          state    <= ST_RUN;
          sync_cnt <= '0;
          if (buf_full) begin
            shreg    <= buf_word;
            buf_full <= 1'b0;
            is_data  <= 1'b1;
          end else begin
            shreg   <= IDLE_WORD;
            is_data <= 1'b0;
          end
        end
      end else if (last_phase) begin
        phase   <= '0;
        bit_idx <= bit_idx - 4'd1;
        shreg   <= {shreg[14:0], 1'b0};
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule
